// File: rtl/pll_mode_ctrl.sv
// PLL mode sequencer: reprograms the PLL fractional multiplier for NTSC/PAL through
// the Avalon-MM reconfig port and holds the core in reset until lock has been stable.
module pll_mode_ctrl #(
    parameter logic [31:0] M_CNT        = 32'h0000_0606,
    parameter logic [31:0] N_CNT        = 32'h0001_0000,
    parameter logic [31:0] C0_CNT       = 32'h0000_0606,
    parameter logic [31:0] C1_CNT       = 32'h0004_0303,
    parameter logic [31:0] K_NTSC       = 32'd3806895803,
    parameter logic [31:0] K_PAL        = 32'd3302065346,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 2000000
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pal,
    input  logic        pll_locked,
    input  logic        mgmt_waitrequest,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    output logic        pll_rst,
    output logic        sys_reset,
    output logic        busy,
    output logic        cur_pal,
    output logic        lock_err
);

    typedef enum logic [3:0] {
        IDLE, W_MODE, W_N, W_M, W_C0, W_C1, W_K, W_START, SETTLE, PRST
    } state_e;

    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(LOCK_TIMEOUT);

    state_e        state_q, state_d;
    logic          pal_meta_q, pal_s_q, lock_meta_q, lock_s_q;
    logic          target_q, target_d;
    logic          cur_pal_q, cur_pal_d;
    logic          lock_err_q, lock_err_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_reset_q, sys_reset_d;
    logic          write_q, write_d;
    logic [5:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    prst_q, prst_d;

    logic          is_wr;
    logic [5:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          accept;

    // NOTE: both asynchronous inputs are reset too, so a stale level cannot trigger a sequence after rst.
    always_ff @(posedge refclk) begin
        if (rst) begin
            pal_meta_q  <= 1'b0;
            pal_s_q     <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            pal_meta_q  <= pal;
            pal_s_q     <= pal_meta_q;
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all next values come from the comb blocks.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= SETTLE;
            target_q    <= 1'b0;
            cur_pal_q   <= 1'b0;
            lock_err_q  <= 1'b0;
            pll_rst_q   <= 1'b0;
            sys_reset_q <= 1'b1;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            stable_q    <= '0;
            tmo_q       <= '0;
            prst_q      <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            cur_pal_q   <= cur_pal_d;
            lock_err_q  <= lock_err_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            stable_q    <= stable_d;
            tmo_q       <= tmo_d;
            prst_q      <= prst_d;
        end
    end

    assign accept = write_q && !mgmt_waitrequest;

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        cur_pal_d   = cur_pal_q;
        lock_err_d  = lock_err_q;
        addr_d      = addr_q;
        data_d      = data_q;

        // Each write state spends one cycle with the strobe low, which gives the gap between writes.
        write_d = is_wr && !accept;
        if (is_wr && !write_q) begin
            addr_d = wr_addr;
            data_d = wr_data;
        end

        if (state_q == SETTLE) begin
            if (!lock_s_q)
                stable_d = '0;
            else if (stable_q == STABLE_MAX)
                stable_d = stable_q;
            else
                stable_d = stable_q + SW'(1);
            tmo_d = tmo_q + TW'(1);
        end else begin
            stable_d = '0;
            tmo_d    = '0;
        end

        prst_d = (state_q == PRST) ? prst_q + 4'd1 : 4'd0;

        case (state_q)
            IDLE: begin
                if (pal_s_q != cur_pal_q) begin
                    target_d = pal_s_q;
                    state_d  = W_MODE;
                end else if (!lock_s_q) begin
                    state_d = SETTLE;
                end
            end
            W_MODE:  if (accept) state_d = W_N;
            W_N:     if (accept) state_d = W_M;
            W_M:     if (accept) state_d = W_C0;
            W_C0:    if (accept) state_d = W_C1;
            W_C1:    if (accept) state_d = W_K;
            W_K:     if (accept) state_d = W_START;
            W_START: begin
                if (accept) begin
                    cur_pal_d = target_q;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (stable_q == STABLE_MAX) begin
                    state_d = IDLE;
                end else if (tmo_q == TIMEOUT_MAX) begin
                    lock_err_d = 1'b1;
                    state_d    = PRST;
                end
            end
            PRST:    if (prst_q == 4'd15) state_d = SETTLE;
            default: state_d = SETTLE;
        endcase

        sys_reset_d = (state_d != IDLE);
        pll_rst_d   = (state_d == PRST);
    end

    always_comb begin
        is_wr   = 1'b0;
        wr_addr = 6'd0;
        wr_data = 32'd0;
        case (state_q)
            W_MODE:  begin is_wr = 1'b1; wr_addr = 6'd0; wr_data = 32'd0;   end
            W_N:     begin is_wr = 1'b1; wr_addr = 6'd3; wr_data = N_CNT;   end
            W_M:     begin is_wr = 1'b1; wr_addr = 6'd4; wr_data = M_CNT;   end
            W_C0:    begin is_wr = 1'b1; wr_addr = 6'd5; wr_data = C0_CNT;  end
            W_C1:    begin is_wr = 1'b1; wr_addr = 6'd5; wr_data = C1_CNT;  end
            W_K:     begin is_wr = 1'b1; wr_addr = 6'd7; wr_data = target_q ? K_PAL : K_NTSC; end
            W_START: begin is_wr = 1'b1; wr_addr = 6'd2; wr_data = 32'd1;   end
            default: ;
        endcase
        busy = (state_q != IDLE);
    end

    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;
    assign mgmt_write     = write_q;
    assign pll_rst        = pll_rst_q;
    assign sys_reset      = sys_reset_q;
    assign cur_pal        = cur_pal_q;
    assign lock_err       = lock_err_q;

endmodule
